// File: rtl/m_clk_div_pkg.sv
// ---------------------------------------------------------------------------
// m_clk_div_pkg
// Shared types and constants for the programmable even-ratio clock divider.
//   state_e    : divider sequencer states
//   DIV_W_DEF  : default width of the ratio code
// ---------------------------------------------------------------------------
package m_clk_div_pkg;

    localparam int DIV_W_DEF = 4;

    // PARK : output held low, counter idle
    // LO   : counting through a low phase
    // HI   : counting through a high phase
    // STOP : final low phase before parking (enable was dropped during HI)
    typedef enum logic [1:0] {
        PARK = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        STOP = 2'd3
    } state_e;

endpackage

// File: rtl/m_buf.sv
// ---------------------------------------------------------------------------
// m_buf
// Clock buffer wrapper placed on the divided clock output. This behavioural
// body stands in for the technology cell; a library-specific variant swaps
// in here without touching the divider.
//   A : clock input (straight from a flop)
//   Z : buffered clock output
// ---------------------------------------------------------------------------
module m_buf (
    input  logic A,
    output logic Z
);

    assign Z = A;

endmodule

// File: rtl/m_clk_div.sv
// ---------------------------------------------------------------------------
// m_clk_div
// Programmable even-ratio clock divider. Divide factor = 2*(code+1).
// Ratio and enable changes only take effect at the end of a complete low
// phase, so the output never produces a shortened high pulse.
// Ports:
//   clk       : source clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : 1 = run, 0 = park output low after the current low phase
//   cfg_req   : request to load cfg_div (accepted when cfg_busy = 0)
//   cfg_div   : new ratio code
//   cfg_busy  : ratio update pending; further requests ignored
//   cfg_ack   : one-cycle pulse when the new ratio becomes active
//   running   : 1 while the divider is toggling
//   rise_stb  : one-cycle pulse in the first cycle clk_out is high
//   clk_out   : divided clock, through the m_buf instance
// ---------------------------------------------------------------------------
module m_clk_div
    import m_clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_busy,
    output logic             cfg_ack,
    output logic             running,
    output logic             rise_stb,
    output logic             clk_out
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    state_e             state_q,     state_d;
    logic [DIV_W-1:0]   cnt_q,       cnt_d;
    logic [DIV_W-1:0]   div_cur_q,   div_cur_d;
    logic [DIV_W-1:0]   div_nxt_q,   div_nxt_d;
    logic               clk_q,       clk_d;
    logic               busy_q,      busy_d;
    logic               ack_q,       ack_d;
    logic               running_q,   running_d;
    logic               rise_q,      rise_d;
    logic               stop_pend_q, stop_pend_d;

    logic               term;
    logic               apply;

    // Terminal count of the current phase; cnt never exceeds div_cur, so
    // the increment below cannot wrap.
    assign term = (cnt_q == div_cur_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_cur_d   = div_cur_q;
        div_nxt_d   = div_nxt_q;
        clk_d       = clk_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        rise_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        apply       = 1'b0;

        // Accept a new ratio only when nothing is pending.
        if (cfg_req && !busy_q) begin
            div_nxt_d = cfg_div;
            busy_d    = 1'b1;
        end

        unique case (state_q)
            PARK: begin
                cnt_d       = '0;
                clk_d       = 1'b0;
                stop_pend_d = 1'b0;
                apply       = busy_q;
                if (en) begin
                    state_d = LO;
                end
            end

            LO, STOP: begin
                if (term) begin
                    // End of a low phase: the only point a ratio may change.
                    cnt_d = '0;
                    apply = busy_q;
                    if (state_q == LO && en) begin
                        clk_d   = 1'b1;
                        rise_d  = 1'b1;
                        state_d = HI;
                    end else begin
                        state_d = PARK;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            HI: begin
                // Remember an enable drop anywhere in the high phase; the
                // high phase itself always runs to completion.
                if (!en) begin
                    stop_pend_d = 1'b1;
                end
                if (term) begin
                    cnt_d       = '0;
                    clk_d       = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = (stop_pend_q || !en) ? STOP : LO;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = PARK;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        if (apply) begin
            div_cur_d = div_nxt_q;
            busy_d    = 1'b0;
            ack_d     = 1'b1;
        end

        running_d = (state_d != PARK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PARK;
            cnt_q       <= '0;
            div_cur_q   <= DIV_RST;
            div_nxt_q   <= DIV_RST;
            clk_q       <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            running_q   <= 1'b0;
            rise_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            div_nxt_q   <= div_nxt_d;
            clk_q       <= clk_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            running_q   <= running_d;
            rise_q      <= rise_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign cfg_busy = busy_q;
    assign cfg_ack  = ack_q;
    assign running  = running_q;
    assign rise_stb = rise_q;

    // clk_q feeds the buffer directly so the output clock is glitch-free.
    m_buf i_clk_out_buf (
        .A (clk_q),
        .Z (clk_out)
    );

endmodule

// File: tb/tb_m_clk_div.sv
module tb_m_clk_div;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_req;
    logic [3:0] cfg_div;
    logic       cfg_busy;
    logic       cfg_ack;
    logic       running;
    logic       rise_stb;
    logic       clk_out;

    int n_checks = 0;
    int n_errors = 0;

    // Expected gaps (in clk cycles) between successive rise_stb pulses.
    int exp_q[$];

    // Ratio model for the phase-length checker.
    int exp_div  = 0;
    int exp_pend = 0;

    typedef struct {
        logic [3:0] code;
        int         first_rise;
        int         period;
    } vec_t;

    m_clk_div #(.DIV_W(4), .DEFAULT_DIV(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_req  (cfg_req),
        .cfg_div  (cfg_div),
        .cfg_busy (cfg_busy),
        .cfg_ack  (cfg_ack),
        .running  (running),
        .rise_stb (rise_stb),
        .clk_out  (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase-length checker: every complete high/low phase lasts div+1 cycles.
    int   ph_len   = 0;
    logic ph_last  = 1'b0;
    logic ph_valid = 1'b0;
    int   ph_div   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph_len   = 0;
            ph_last  = 1'b0;
            ph_valid = 1'b0;
            exp_div  = 0;
        end else begin
            if (cfg_ack) exp_div = exp_pend;
            if (clk_out == ph_last) begin
                ph_len++;
            end else begin
                if (ph_valid) check("phase_len", ph_len, ph_div + 1);
                ph_len   = 1;
                ph_last  = clk_out;
                ph_div   = exp_div;
                ph_valid = 1'b1;
            end
            // A low phase that spans a park is not a divider phase.
            if (!clk_out && !running) ph_valid = 1'b0;
        end
    end

    // Pop and compare expected rise gaps as rise_stb pulses arrive.
    task automatic run_sb(input int budget);
        int gap = 0;
        int i   = 0;
        int e;
        while (exp_q.size() > 0 && i < budget) begin
            @(negedge clk);
            i++;
            gap++;
            if (rise_stb) begin
                e = exp_q.pop_front();
                $display("rise: gap=%0d expected=%0d", gap, e);
                check("rise_gap", gap, e);
                gap = 0;
            end
        end
        if (exp_q.size() > 0) begin
            check("sb_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic sync_rise();
        int i = 0;
        @(negedge clk);
        while (!rise_stb && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!rise_stb) check("rise_timeout", rise_stb, 1);
    endtask

    task automatic wait_park();
        int i = 0;
        while (running && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("park_running", running, 0);
        check("park_clk", clk_out, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int hi;
        int lo;
        int acks;
        int i;

        vecs[0] = '{code: 4'd0,  first_rise: 2,  period: 2};
        vecs[1] = '{code: 4'd1,  first_rise: 3,  period: 4};
        vecs[2] = '{code: 4'd15, first_rise: 17, period: 32};
        vecs[3] = '{code: 4'd3,  first_rise: 5,  period: 8};
        vecs[4] = '{code: 4'd2,  first_rise: 4,  period: 6};

        rst_n   = 1'b0;
        en      = 1'b0;
        cfg_req = 1'b0;
        cfg_div = 4'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_clk_out", clk_out, 0);
        check("rst_running", running, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", cfg_busy, 0);
        check("rst_ack", cfg_ack, 0);
        check("rst_rise", rise_stb, 0);
        $display("seq reset: done");

        // Default /2 after reset
        en = 1'b1;
        exp_q.push_back(2);
        repeat (4) exp_q.push_back(2);
        run_sb(40);
        check("div2_running", running, 1);
        $display("seq default /2: done");

        // Ratio change to 3 while running at /2
        exp_pend = 3;
        cfg_div  = 4'd3;
        cfg_req  = 1'b1;
        @(negedge clk);
        check("cfg_busy_set", cfg_busy, 1);
        cfg_req = 1'b0;
        i = 0;
        while (!cfg_ack && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("ack_seen", cfg_ack, 1);
        check("ack_at_rise_clk", clk_out, 1);
        check("ack_at_rise_stb", rise_stb, 1);
        check("ack_busy_clr", cfg_busy, 0);
        exp_q.push_back(8);
        exp_q.push_back(8);
        run_sb(60);
        $display("seq ratio /2 -> /8: done");

        // Ratio 2, drop en mid high phase
        exp_pend = 2;
        cfg_div  = 4'd2;
        cfg_req  = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        i = 0;
        while (!cfg_ack && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("ack_div2", cfg_ack, 1);
        sync_rise();
        hi = 1;
        i  = 0;
        while (i < 50) begin
            @(negedge clk);
            i++;
            if (i == 1) en = 1'b0;
            if (clk_out) hi++;
            else break;
        end
        check("stop_hi_len", hi, 3);
        lo = 1;
        i  = 0;
        while (i < 50) begin
            @(negedge clk);
            i++;
            if (running && !clk_out) lo++;
            else break;
        end
        check("stop_lo_len", lo, 3);
        check("stop_running", running, 0);
        check("stop_clk", clk_out, 0);
        $display("seq en drop in high: hi=%0d lo=%0d", hi, lo);

        // Second request while busy is ignored
        en = 1'b1;
        repeat (2) @(negedge clk);
        exp_pend = 1;
        cfg_div  = 4'd1;
        cfg_req  = 1'b1;
        acks = 0;
        @(negedge clk);
        if (cfg_ack) acks++;
        cfg_div = 4'd5;
        @(negedge clk);
        if (cfg_ack) acks++;
        cfg_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cfg_ack) acks++;
        end
        check("single_ack", acks, 1);
        sync_rise();
        exp_q.push_back(4);
        exp_q.push_back(4);
        run_sb(40);
        en = 1'b0;
        wait_park();
        $display("seq busy ignore: acks=%0d", acks);

        // Table: program while parked, then run
        foreach (vecs[k]) begin
            exp_pend = vecs[k].code;
            cfg_div  = vecs[k].code;
            cfg_req  = 1'b1;
            @(negedge clk);
            check("park_busy", cfg_busy, 1);
            check("park_ack_early", cfg_ack, 0);
            cfg_req = 1'b0;
            @(negedge clk);
            check("park_ack", cfg_ack, 1);
            en = 1'b1;
            exp_q.push_back(vecs[k].first_rise);
            repeat (3) exp_q.push_back(vecs[k].period);
            run_sb(200);
            en = 1'b0;
            wait_park();
            $display("vec code=%0d first=%0d period=%0d: done",
                     vecs[k].code, vecs[k].first_rise, vecs[k].period);
        end

        // Reset asserted mid high phase
        en = 1'b1;
        sync_rise();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_clk", clk_out, 0);
        check("rst_async_run", running, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_clk", clk_out, 0);
        check("post_rst_run", running, 0);
        check("post_rst_busy", cfg_busy, 0);
        check("post_rst_ack", cfg_ack, 0);
        check("post_rst_rise", rise_stb, 0);
        en = 1'b1;
        exp_q.push_back(2);
        repeat (3) exp_q.push_back(2);
        run_sb(40);
        en = 1'b0;
        wait_park();
        $display("seq reset mid high: done");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
